// File: rtl/gate_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gate_vector_checker
//  Purpose  : Stimulus and response stage for the basic-gate bank. Sweeps all
//             16 {A,B,C,D} combinations and samples the ten gate outputs after
//             a settle window. Compares them with locally computed expected
//             values, then reports error count, a sticky per-gate mismatch mask
//             and the first failing vector.
//  Ports    : clk              - rising-edge clock
//             rst_n            - asynchronous active-low reset
//             start            - sweep start pulse (honoured in IDLE/DONE)
//             vec_out[3:0]     - stimulus {A,B,C,D} to the gate bank
//             dut_y[9:0]       - gate bank outputs (NOT..NOR4)
//             busy             - sweep in progress (DRIVE or CHECK)
//             done             - sweep complete
//             pass             - sweep complete with zero errors
//             err_count[4:0]   - number of failing vectors (0..16)
//             mismatch_mask    - sticky OR of per-gate differences
//             first_fail_vec   - vector of the first failing check
//             first_fail_valid - first_fail_vec holds a captured vector
//  Revision : 1.0 - initial release
// ============================================================================
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  COMBO_TT      = 4'b0110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] vec_out,
  input  logic [9:0] dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [9:0] mismatch_mask,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);

  state_t     r_state;
  logic [3:0] r_settle_cnt;

  logic       w_a;
  logic       w_b;
  logic       w_c;
  logic       w_d;
  logic [9:0] w_expected;
  logic [9:0] w_diff;
  logic       w_mismatch;
  logic [4:0] w_err_next;

  assign w_a = vec_out[3];
  assign w_b = vec_out[2];
  assign w_c = vec_out[1];
  assign w_d = vec_out[0];

  // Reference response, packed in the same bit order as dut_y.
  always_comb begin
    w_expected = {~w_a,
                  w_a & w_b,
                  w_a | w_b,
                  ~(w_a & w_b),
                  ~(w_a | w_b),
                  w_a ^ w_b,
                  ~(w_a ^ w_b),
                  w_a,
                  COMBO_TT[{w_a, w_b}],
                  ~(w_a | w_b | w_c | w_d)};
    w_diff     = dut_y ^ w_expected;
    w_mismatch = |w_diff;
    w_err_next = err_count + {4'd0, w_mismatch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_settle_cnt     <= 4'd0;
      vec_out          <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 5'd0;
      mismatch_mask    <= 10'd0;
      first_fail_vec   <= 4'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE on start: results are wiped and a fresh
        // sweep begins; otherwise they are held.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state          <= S_DRIVE;
            r_settle_cnt     <= c_settle;
            vec_out          <= 4'd0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            mismatch_mask    <= 10'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
          end
        end

        // Counter is loaded with SETTLE_CYCLES, so leaving when it reads 1
        // gives exactly SETTLE_CYCLES cycles of DRIVE.
        S_DRIVE: begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
          if (r_settle_cnt <= 4'd1) begin
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            err_count     <= w_err_next;
            mismatch_mask <= mismatch_mask | w_diff;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec_out;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec_out == 4'hF) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_next == 5'd0);
          end else begin
            r_state      <= S_DRIVE;
            vec_out      <= vec_out + 4'd1;
            r_settle_cnt <= c_settle;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
